prng_stream: RTL and testbench
==============================

PRNG_STREAM -- requirements
Module: prng_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each channel's state and output word; legal range 18..64.
REQ-002 Parameter NUM_CH, default 4, number of independent generator channels; legal range 1..16.
REQ-003 Parameter SEED, default 123456, reset seed base.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port enable, input, 1, permits generation of new words.
REQ-007 Port mode, input, 1: 0 = LCG, 1 = xorshift. Sampled on every state advance.
REQ-008 Port seed_load, input, 1, single-cycle reseed request.
REQ-009 Port seed_in, input, DATA_WIDTH, seed base used with seed_load.
REQ-010 Port out_data, output, NUM_CH*DATA_WIDTH; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 Port out_valid, output, 1, out_data holds an unconsumed word set.
REQ-012 Port out_ready, input, 1, consumer accepts out_data this cycle.
REQ-013 Port gen_count, output, 32, number of accepted transfers since reset or reseed.

Function
REQ-014 Each channel k SHALL hold a DATA_WIDTH state register. Its next value f(s) SHALL be defined as follows; all arithmetic is truncated modulo 2^DATA_WIDTH.
- LCG (mode 0): f(s) = s*1103515245 + 12345.
- Xorshift (mode 1): s ^= s<<13; s ^= s>>17; s ^= s<<5.
REQ-015 In mode 1 with s == 0, f(s) SHALL be the LCG result, so that no channel locks at zero.
REQ-016 The FSM SHALL have exactly two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
REQ-017 EMPTY with enable = 1: on the next edge, every state[k] <= f(state[k]), out_data[k] <= f(state[k]), and the FSM goes to FULL. Latency from enable to out_valid is 1 cycle.
REQ-018 EMPTY with enable = 0: all registers SHALL hold.
REQ-019 FULL with out_ready = 0: out_data, out_valid and states SHALL remain stable, whatever the value of enable.
REQ-020 FULL with out_ready = 1 and enable = 1: states SHALL advance and out_data SHALL reload as in REQ-017, out_valid stays 1, and gen_count increments. Throughput is 1 word set per cycle.
REQ-021 FULL with out_ready = 1 and enable = 0: gen_count increments, the FSM goes to EMPTY, and states hold.
REQ-022 seed_load = 1 SHALL take priority over every other condition:
- state[k] <= seed_in + k (mod 2^DATA_WIDTH);
- out_valid <= 0 and the FSM goes to EMPTY;
- gen_count <= 0;
- any pending word is discarded and no transfer is counted that cycle, even if out_ready = 1.
REQ-023 gen_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 A change of mode SHALL affect only subsequent advances; a word already held in out_data is unchanged.
REQ-025 Channels SHALL never interact; each channel depends only on its own state.

Reset
REQ-026 While rst_n = 0, independent of clk:
- state[k] = SEED + k;
- out_data = 0;
- out_valid = 0;
- FSM = EMPTY;
- gen_count = 0.
REQ-027 Reset asserted mid-stream SHALL discard the held word. After release, the first out_valid SHALL appear 1 cycle after enable is sampled high.
REQ-028 All non-reset updates SHALL use nonblocking assignment on the rising edge of clk only.

Verification
REQ-029 Defaults, release reset, mode = 0, enable = 1, out_ready = 1 -> after 1 cycle out_valid = 1, channel 0 = 3510437241, and channel k = f(123456 + k).
REQ-030 seed_in = 1, seed_load pulse, mode = 1, enable = 1 -> channel 0 = 0x00042021 on the first valid cycle.
REQ-031 Stream running, out_ready held 0 for 5 cycles -> out_data and gen_count are frozen; after out_ready returns to 1, the sequence continues with no word skipped or repeated.
REQ-032 mode = 1, seed_in = 0 (channel 0 state 0) -> channel 0 next word = 12345, never 0.
REQ-033 seed_load asserted together with out_valid = 1 and out_ready = 1 -> out_valid = 0 next cycle, gen_count = 0, and the next word is f(seed_in + k).
REQ-034 Force gen_count to 0xFFFFFFFF (run or preload), then complete one transfer -> gen_count = 0; separately, rst_n pulse mid-stream -> all outputs are 0 immediately.

Source files
------------

// File: rtl/prng_stream.sv
// Multi-channel PRNG word source: each channel runs an LCG or xorshift generator,
// and the word set is presented through a one-deep valid/ready output register.

module prng_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] state,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] nxt
);
    localparam logic [DATA_WIDTH-1:0] LCG_MUL = DATA_WIDTH'(64'd1103515245);
    localparam logic [DATA_WIDTH-1:0] LCG_INC = DATA_WIDTH'(64'd12345);

    logic [DATA_WIDTH-1:0] lcg;
    logic [DATA_WIDTH-1:0] x1, x2, x3;

    always_comb begin
        lcg = state * LCG_MUL + LCG_INC;
        x1  = state ^ (state << 13);
        x2  = x1 ^ (x1 >> 17);
        x3  = x2 ^ (x2 << 5);
        // xorshift has a fixed point at zero; fall back to LCG to escape it
        nxt = (mode && (state != '0)) ? x3 : lcg;
    end
endmodule

module prng_stream #(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_CH     = 4,
    parameter int unsigned SEED       = 123456
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         mode,
    input  logic                         seed_load,
    input  logic [DATA_WIDTH-1:0]        seed_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  gen_count
);
    typedef enum logic {EMPTY, FULL} fsm_t;

    fsm_t cur, nxt_st;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] st_q, st_nxt, data_q;
    logic [31:0] gen_cnt;
    logic        advance, accept;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        prng_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .state (st_q[k]),
            .mode  (mode),
            .nxt   (st_nxt[k])
        );
    end

    always_comb begin
        nxt_st  = cur;
        advance = 1'b0;
        accept  = 1'b0;
        if (seed_load) begin
            nxt_st = EMPTY;
        end else begin
            case (cur)
                EMPTY: begin
                    if (enable) begin
                        advance = 1'b1;
                        nxt_st  = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        accept = 1'b1;
                        if (enable) advance = 1'b1;
                        else        nxt_st  = EMPTY;
                    end
                end
                default: nxt_st = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= EMPTY;
            gen_cnt <= '0;
            data_q  <= '0;
            for (int k = 0; k < NUM_CH; k++)
                st_q[k] <= DATA_WIDTH'(SEED) + DATA_WIDTH'(k);
        end else begin
            cur <= nxt_st;
            if (seed_load) begin
                // held word is dropped by clearing valid; data register keeps stale bits
                gen_cnt <= '0;
                for (int k = 0; k < NUM_CH; k++)
                    st_q[k] <= seed_in + DATA_WIDTH'(k);
            end else begin
                if (accept) gen_cnt <= gen_cnt + 32'd1;
                if (advance) begin
                    st_q   <= st_nxt;
                    data_q <= st_nxt;
                end
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = (cur == FULL);
    assign gen_count = gen_cnt;
endmodule

// File: tb/tb_prng_stream.sv
// Directed checks of prng_stream: vector table plus stall, counter-wrap and
// asynchronous-reset sequences, checked against a small reference model.

module tb_prng_stream;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int unsigned SEED = 123456;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable, mode, seed_load, out_ready;
    logic [DW-1:0]     seed_in;
    logic [NC*DW-1:0]  out_data;
    logic              out_valid;
    logic [31:0]       gen_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mst   [NC];
    logic [DW-1:0] mdata [NC];
    logic          mvalid;
    logic [31:0]   mcount;

    prng_stream #(.DATA_WIDTH(DW), .NUM_CH(NC), .SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] f(input logic [DW-1:0] s, input logic m);
        logic [63:0] p;
        logic [DW-1:0] x;
        if (m && s != 0) begin
            x = s;
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
            return x;
        end
        p = {32'd0, s} * 64'd1103515245 + 64'd12345;
        return p[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            mst[k]   = DW'(SEED) + DW'(k);
            mdata[k] = '0;
        end
        mvalid = 1'b0;
        mcount = '0;
    endtask

    task automatic model_edge(input logic en, input logic md, input logic sl,
                              input logic [DW-1:0] si, input logic rdy);
        bit adv = 0;
        if (sl) begin
            for (int k = 0; k < NC; k++) mst[k] = si + DW'(k);
            mvalid = 1'b0;
            mcount = '0;
        end else if (!mvalid) begin
            adv = en;
        end else if (rdy) begin
            mcount = mcount + 32'd1;
            if (en) adv = 1;
            else    mvalid = 1'b0;
        end
        if (adv) begin
            for (int k = 0; k < NC; k++) begin
                mst[k]   = f(mst[k], md);
                mdata[k] = mst[k];
            end
            mvalid = 1'b1;
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(mvalid));
        chk({tag, ".count"}, 64'(gen_count), 64'(mcount));
        if (mvalid)
            for (int k = 0; k < NC; k++)
                chk($sformatf("%s.ch%0d", tag, k), 64'(out_data[k*DW +: DW]), 64'(mdata[k]));
    endtask

    // drive at negedge, clock once, compare at next negedge
    task automatic step(input logic en, input logic md, input logic sl,
                        input logic [DW-1:0] si, input logic rdy, input string tag);
        enable = en; mode = md; seed_load = sl; seed_in = si; out_ready = rdy;
        @(posedge clk);
        model_edge(en, md, sl, si, rdy);
        @(negedge clk);
        cmp_model(tag);
    endtask

    typedef struct {
        logic          en, md, sl, rdy;
        logic [DW-1:0] si;
        logic          ev;
        logic [31:0]   ec;
        logic          chk0;
        logic [DW-1:0] e0;
    } vec_t;

    vec_t vecs[13];
    logic [DW-1:0] hold0;
    logic [31:0]   holdc;

    initial begin
        vecs[0]  = '{1,0,0,1, 0, 1, 0, 1, 32'd3510437241};
        vecs[1]  = '{1,0,0,1, 0, 1, 1, 0, 0};
        vecs[2]  = '{1,1,0,1, 0, 1, 2, 0, 0};
        vecs[3]  = '{0,0,0,0, 0, 1, 2, 0, 0};
        vecs[4]  = '{1,0,0,0, 0, 1, 2, 0, 0};
        vecs[5]  = '{0,0,0,1, 0, 0, 3, 0, 0};
        vecs[6]  = '{0,0,0,1, 0, 0, 3, 0, 0};
        vecs[7]  = '{1,1,0,0, 0, 1, 3, 0, 0};
        vecs[8]  = '{1,1,1,1, 1, 0, 0, 0, 0};
        vecs[9]  = '{1,1,0,1, 0, 1, 0, 1, 32'h00042021};
        vecs[10] = '{0,1,1,0, 0, 0, 0, 0, 0};
        vecs[11] = '{1,1,0,1, 0, 1, 0, 1, 32'd12345};
        vecs[12] = '{1,0,0,1, 0, 1, 1, 0, 0};

        rst_n = 1'b0; enable = 0; mode = 0; seed_load = 0; seed_in = '0; out_ready = 0;
        model_reset();
        #12;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.data",  64'(out_data == '0), 64'd1);
        chk("rst.count", 64'(gen_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].en, vecs[i].md, vecs[i].sl, vecs[i].si, vecs[i].rdy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tvalid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d.tcount", i), 64'(gen_count), 64'(vecs[i].ec));
            if (vecs[i].chk0)
                chk($sformatf("vec%0d.tch0", i), 64'(out_data[DW-1:0]), 64'(vecs[i].e0));
        end

        // back-pressure: 5 stalled cycles then resume with no skip or repeat
        step(1, 0, 0, 0, 1, "pre");
        hold0 = out_data[DW-1:0];
        holdc = gen_count;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, $sformatf("stall%0d", i));
            chk($sformatf("stall%0d.frz_data", i), 64'(out_data[DW-1:0]), 64'(hold0));
            chk($sformatf("stall%0d.frz_cnt", i), 64'(gen_count), 64'(holdc));
        end
        step(1, 0, 0, 0, 1, "resume");
        chk("resume.next", 64'(out_data[DW-1:0]), 64'(f(hold0, 1'b0)));
        chk("resume.cnt", 64'(gen_count), 64'(holdc + 32'd1));

        // counter wrap: preload all-ones while stalled, then one transfer
        step(1, 0, 0, 0, 0, "prewrap");
        force dut.gen_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.gen_cnt;
        mcount = 32'hFFFF_FFFF;
        step(1, 0, 0, 0, 1, "wrap");
        chk("wrap.zero", 64'(gen_count), 64'd0);

        // asynchronous reset mid-stream
        step(1, 0, 0, 0, 1, "prerst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(out_valid), 64'd0);
        chk("arst.data",  64'(out_data == '0), 64'd1);
        chk("arst.count", 64'(gen_count), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 1, "postrst");
        chk("postrst.ch0", 64'(out_data[DW-1:0]), 64'd3510437241);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
